// File: rtl/readout_pkg.sv
// rtl/readout_pkg.sv - shared readout state encoding and default geometry
package readout_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam int NCH_DEF    = 8;
    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 12;

endpackage

// File: rtl/multichannel_readout_sequencer_next_enabled_channel.sv
// rtl/multichannel_readout_sequencer_next_enabled_channel.sv - finds the lowest set mask bit above cur
module next_enabled_channel #(
    parameter int NCH  = 8,
    parameter int CH_W = 4
) (
    input  logic [NCH-1:0]  mask,
    input  logic [CH_W-1:0] cur,
    input  logic            start,
    output logic [CH_W-1:0] nxt,
    output logic            found
);

    // Scanning downward lets the lowest qualifying channel overwrite the others;
    // start treats cur as -1 so channel 0 qualifies.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (mask[k] && (start || (CH_W'(k) > cur))) begin
                nxt   = CH_W'(k);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multichannel_readout_sequencer.sv
// rtl/multichannel_readout_sequencer.sv - walks enabled channel buffers one SPI word at a time
module multichannel_readout_sequencer
    import readout_pkg::*;
#(
    parameter int NCH    = NCH_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int WCNT_W = 16,
    parameter int CH_W   = 4
) (
    input  logic                  sysclk,
    input  logic                  rst,
    input  logic                  spi_ss,
    input  logic                  spi_done,
    input  logic [WCNT_W-1:0]     word_num,
    input  logic [NCH-1:0]        ch_enable,
    input  logic [NCH*DATA_W-1:0] chan_data,
    output logic [ADDR_W-1:0]     read_address,
    output logic [CH_W-1:0]       read_channel,
    output logic [DATA_W-1:0]     data_out,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  spurious
);

    localparam logic [WCNT_W:0] MAX_WORDS = {{WCNT_W{1'b0}}, 1'b1} << ADDR_W;
    localparam logic [WCNT_W:0] ONE_W     = {{WCNT_W{1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                fd_q, fd_d;
    logic                sp_q, sp_d;
    logic [WCNT_W:0]     lim_q, lim_d;
    logic [NCH-1:0]      en_q, en_d;

    logic [WCNT_W:0]     wn_ext;
    logic [WCNT_W:0]     wn_clamped;
    logic [WCNT_W:0]     addr_ext;
    logic [NCH-1:0]      f_mask;
    logic                f_start;
    logic [CH_W-1:0]     f_next;
    logic                f_found;

    assign wn_ext     = {1'b0, word_num};
    assign wn_clamped = (wn_ext > MAX_WORDS) ? MAX_WORDS : wn_ext;
    assign addr_ext   = {{(WCNT_W + 1 - ADDR_W){1'b0}}, addr_q};

    // In IDLE the finder looks at the live mask for the first channel; otherwise
    // it advances through the latched mask.
    assign f_start = (state_q == ST_IDLE);
    assign f_mask  = (state_q == ST_IDLE) ? ch_enable : en_q;

    next_enabled_channel #(
        .NCH  (NCH),
        .CH_W (CH_W)
    ) u_next (
        .mask  (f_mask),
        .cur   (ch_q),
        .start (f_start),
        .nxt   (f_next),
        .found (f_found)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ch_d    = ch_q;
        lim_d   = lim_q;
        en_d    = en_q;
        fd_d    = 1'b0;
        sp_d    = sp_q;
        dout_d  = chan_data[ch_q*DATA_W +: DATA_W];

        if (spi_ss) begin
            state_d = ST_IDLE;
            addr_d  = '0;
            ch_d    = '0;
            lim_d   = '0;
            en_d    = '0;
            if (spi_done && (state_q != ST_ACTIVE)) begin
                sp_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    lim_d  = wn_clamped;
                    en_d   = ch_enable;
                    addr_d = '0;
                    ch_d   = f_found ? f_next : '0;
                    sp_d   = 1'b0;
                    if ((ch_enable == '0) || (wn_clamped == '0)) begin
                        state_d = ST_DONE;
                        fd_d    = 1'b1;
                    end else begin
                        state_d = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (spi_done) begin
                        if (addr_ext < (lim_q - ONE_W)) begin
                            addr_d = addr_q + ADDR_W'(1);
                        end else begin
                            addr_d = '0;
                            if (f_found) begin
                                ch_d = f_next;
                            end else begin
                                state_d = ST_DONE;
                                fd_d    = 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (spi_done) begin
                        sp_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            ch_q    <= '0;
            dout_q  <= '0;
            fd_q    <= 1'b0;
            sp_q    <= 1'b0;
            lim_q   <= '0;
            en_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ch_q    <= ch_d;
            dout_q  <= dout_d;
            fd_q    <= fd_d;
            sp_q    <= sp_d;
            lim_q   <= lim_d;
            en_q    <= en_d;
        end
    end

    assign read_address = addr_q;
    assign read_channel = ch_q;
    assign data_out     = dout_q;
    assign busy         = (state_q == ST_ACTIVE);
    assign frame_done   = fd_q;
    assign spurious     = sp_q;

endmodule

// File: tb/tb_multichannel_readout_sequencer.sv
// tb/tb_multichannel_readout_sequencer.sv - directed vector bench for the readout sequencer
module tb_multichannel_readout_sequencer;

    localparam int NCH    = 8;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 12;
    localparam int WCNT_W = 16;
    localparam int CH_W   = 4;

    logic                  sysclk = 1'b0;
    logic                  rst;
    logic                  spi_ss;
    logic                  spi_done;
    logic [WCNT_W-1:0]     word_num;
    logic [NCH-1:0]        ch_enable;
    logic [NCH*DATA_W-1:0] chan_data;
    logic [ADDR_W-1:0]     read_address;
    logic [CH_W-1:0]       read_channel;
    logic [DATA_W-1:0]     data_out;
    logic                  busy;
    logic                  frame_done;
    logic                  spurious;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        ss;
        logic        done;
        logic [15:0] wn;
        logic [7:0]  en;
        logic [9:0]  e_addr;
        logic [3:0]  e_ch;
        logic [11:0] e_dout;
        logic        e_busy;
        logic        e_fd;
        logic        e_sp;
    } vec_t;

    vec_t tbl[$];

    always #5 sysclk = ~sysclk;

    multichannel_readout_sequencer #(
        .NCH    (NCH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .WCNT_W (WCNT_W),
        .CH_W   (CH_W)
    ) dut (
        .sysclk       (sysclk),
        .rst          (rst),
        .spi_ss       (spi_ss),
        .spi_done     (spi_done),
        .word_num     (word_num),
        .ch_enable    (ch_enable),
        .chan_data    (chan_data),
        .read_address (read_address),
        .read_channel (read_channel),
        .data_out     (data_out),
        .busy         (busy),
        .frame_done   (frame_done),
        .spurious     (spurious)
    );

    function automatic vec_t mk(logic r, logic s, logic d, logic [15:0] wn, logic [7:0] en,
                                logic [9:0] a, logic [3:0] c, logic [11:0] o,
                                logic b, logic f, logic sp);
        vec_t v;
        v.rst = r; v.ss = s; v.done = d; v.wn = wn; v.en = en;
        v.e_addr = a; v.e_ch = c; v.e_dout = o; v.e_busy = b; v.e_fd = f; v.e_sp = sp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic d,
                        input logic [15:0] wn, input logic [7:0] en);
        rst = r; spi_ss = s; spi_done = d; word_num = wn; ch_enable = en;
        @(posedge sysclk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < NCH; k++) begin
            chan_data[k*DATA_W +: DATA_W] = 12'hA00 + 12'(k);
        end

        // two-channel frame of four words each
        tbl.push_back(mk(1,1,0, 16'd4, 8'h05, 0,0,12'h000, 0,0,0));
        tbl.push_back(mk(1,1,0, 16'd4, 8'h05, 0,0,12'h000, 0,0,0));
        tbl.push_back(mk(0,0,0, 16'd4, 8'h05, 0,0,12'hA00, 1,0,0));
        tbl.push_back(mk(0,0,1, 16'd4, 8'h05, 1,0,12'hA00, 1,0,0));
        tbl.push_back(mk(0,0,1, 16'd4, 8'h05, 2,0,12'hA00, 1,0,0));
        tbl.push_back(mk(0,0,1, 16'd4, 8'h05, 3,0,12'hA00, 1,0,0));
        tbl.push_back(mk(0,0,1, 16'd4, 8'h05, 0,2,12'hA00, 1,0,0));
        tbl.push_back(mk(0,0,1, 16'd4, 8'h05, 1,2,12'hA02, 1,0,0));
        tbl.push_back(mk(0,0,1, 16'd4, 8'h05, 2,2,12'hA02, 1,0,0));
        tbl.push_back(mk(0,0,1, 16'd4, 8'h05, 3,2,12'hA02, 1,0,0));
        tbl.push_back(mk(0,0,1, 16'd4, 8'h05, 0,2,12'hA02, 0,1,0));
        tbl.push_back(mk(0,0,0, 16'd4, 8'h05, 0,2,12'hA02, 0,0,0));
        tbl.push_back(mk(0,0,1, 16'd4, 8'h05, 0,2,12'hA02, 0,0,1));
        tbl.push_back(mk(0,1,0, 16'd4, 8'h05, 0,0,12'hA02, 0,0,1));
        tbl.push_back(mk(0,1,0, 16'd4, 8'h05, 0,0,12'hA00, 0,0,1));
        // empty mask, then zero word count
        tbl.push_back(mk(0,0,0, 16'd4, 8'h00, 0,0,12'hA00, 0,1,0));
        tbl.push_back(mk(0,0,0, 16'd4, 8'h00, 0,0,12'hA00, 0,0,0));
        tbl.push_back(mk(0,0,1, 16'd4, 8'h00, 0,0,12'hA00, 0,0,1));
        tbl.push_back(mk(1,0,0, 16'd4, 8'h00, 0,0,12'h000, 0,0,0));
        tbl.push_back(mk(0,1,0, 16'd0, 8'hFF, 0,0,12'hA00, 0,0,0));
        tbl.push_back(mk(0,0,0, 16'd0, 8'hFF, 0,0,12'hA00, 0,1,0));
        tbl.push_back(mk(0,0,0, 16'd0, 8'hFF, 0,0,12'hA00, 0,0,0));
        tbl.push_back(mk(0,1,0, 16'd0, 8'hFF, 0,0,12'hA00, 0,0,0));
        // abort after five words, restart, mid-frame input changes, reset at address 7
        tbl.push_back(mk(0,0,0, 16'd16, 8'hFF, 0,0,12'hA00, 1,0,0));
        for (int i = 1; i <= 5; i++)
            tbl.push_back(mk(0,0,1, 16'd16, 8'hFF, 10'(i),0,12'hA00, 1,0,0));
        tbl.push_back(mk(0,1,0, 16'd16, 8'hFF, 0,0,12'hA00, 0,0,0));
        tbl.push_back(mk(0,0,0, 16'd16, 8'hFF, 0,0,12'hA00, 1,0,0));
        for (int i = 1; i <= 7; i++)
            tbl.push_back(mk(0,0,1, 16'd1, 8'h00, 10'(i),0,12'hA00, 1,0,0));
        tbl.push_back(mk(1,0,0, 16'd1, 8'h00, 0,0,12'h000, 0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].ss, tbl[i].done, tbl[i].wn, tbl[i].en);
            chk($sformatf("v%0d read_address", i), 32'(read_address), 32'(tbl[i].e_addr));
            chk($sformatf("v%0d read_channel", i), 32'(read_channel), 32'(tbl[i].e_ch));
            chk($sformatf("v%0d data_out", i),     32'(data_out),     32'(tbl[i].e_dout));
            chk($sformatf("v%0d busy", i),         32'(busy),         32'(tbl[i].e_busy));
            chk($sformatf("v%0d frame_done", i),   32'(frame_done),   32'(tbl[i].e_fd));
            chk($sformatf("v%0d spurious", i),     32'(spurious),     32'(tbl[i].e_sp));
        end

        // word count clamps to 1024 per channel
        step(0, 1, 0, 16'hFFFF, 8'h03);
        step(0, 0, 0, 16'hFFFF, 8'h03);
        for (int i = 1; i <= 1023; i++) step(0, 0, 1, 16'hFFFF, 8'h03);
        chk("clamp addr_1023", 32'(read_address), 32'd1023);
        chk("clamp ch_before", 32'(read_channel), 32'd0);
        step(0, 0, 1, 16'hFFFF, 8'h03);
        chk("clamp addr_wrap", 32'(read_address), 32'd0);
        chk("clamp ch_adv", 32'(read_channel), 32'd1);
        chk("clamp busy", 32'(busy), 32'd1);
        for (int i = 1; i <= 1023; i++) step(0, 0, 1, 16'hFFFF, 8'h03);
        chk("clamp no_early_done", 32'(frame_done), 32'd0);
        step(0, 0, 1, 16'hFFFF, 8'h03);
        chk("clamp frame_done", 32'(frame_done), 32'd1);
        chk("clamp busy_off", 32'(busy), 32'd0);
        chk("clamp last_ch", 32'(read_channel), 32'd1);

        // data_out follows the channel one cycle later across a sparse mask
        step(0, 1, 0, 16'd1, 8'h82);
        step(0, 0, 0, 16'd1, 8'h82);
        chk("mux first_ch", 32'(read_channel), 32'd1);
        step(0, 0, 0, 16'd1, 8'h82);
        chk("mux dout_ch1", 32'(data_out), 32'hA01);
        step(0, 0, 1, 16'd1, 8'h82);
        chk("mux ch7", 32'(read_channel), 32'd7);
        chk("mux dout_lag", 32'(data_out), 32'hA01);
        step(0, 0, 0, 16'd1, 8'h82);
        chk("mux dout_ch7", 32'(data_out), 32'hA07);
        step(0, 0, 1, 16'd1, 8'h82);
        chk("mux frame_done", 32'(frame_done), 32'd1);
        chk("mux ch_hold", 32'(read_channel), 32'd7);

        // spi_done while idle is flagged
        step(0, 1, 0, 16'd1, 8'h82);
        chk("idle sp_clear", 32'(spurious), 32'd0);
        step(0, 1, 1, 16'd1, 8'h82);
        chk("idle spurious", 32'(spurious), 32'd1);
        chk("idle busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
